// File: rtl/soc_bus_pkg.sv
// Shared bus definitions for the arbiter: state encoding, master IDs and bus widths.
package soc_bus_pkg;

  localparam int unsigned BUS_ADDR_W    = 32;
  localparam int unsigned BUS_DATA_W    = 32;
  localparam int unsigned BUS_STRB_W    = 4;
  localparam int unsigned TIMEOUT_CNT_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam logic CPU = 1'b0;
  localparam logic DMA = 1'b1;

  typedef struct packed {
    logic [BUS_ADDR_W-1:0] addr;
    logic [BUS_DATA_W-1:0] wdata;
    logic [BUS_STRB_W-1:0] wstrb;
  } bus_req_t;

endpackage

// File: rtl/bus_arbiter_if.sv
// Two-master / one-slave bus bundle; slave modport is the arbiter's view, master the environment's.
interface bus_arbiter_if;
  import soc_bus_pkg::*;

  logic                  m0_valid;
  logic [BUS_ADDR_W-1:0] m0_addr;
  logic [BUS_DATA_W-1:0] m0_wdata;
  logic [BUS_STRB_W-1:0] m0_wstrb;
  logic                  m0_ready;
  logic [BUS_DATA_W-1:0] m0_rdata;
  logic                  m0_err;

  logic                  m1_valid;
  logic [BUS_ADDR_W-1:0] m1_addr;
  logic [BUS_DATA_W-1:0] m1_wdata;
  logic [BUS_STRB_W-1:0] m1_wstrb;
  logic                  m1_ready;
  logic [BUS_DATA_W-1:0] m1_rdata;
  logic                  m1_err;

  logic                  s_valid;
  logic [BUS_ADDR_W-1:0] s_addr;
  logic [BUS_DATA_W-1:0] s_wdata;
  logic [BUS_STRB_W-1:0] s_wstrb;
  logic                  s_ready;
  logic [BUS_DATA_W-1:0] s_rdata;

  modport slave (
    input  m0_valid, m0_addr, m0_wdata, m0_wstrb,
    output m0_ready, m0_rdata, m0_err,
    input  m1_valid, m1_addr, m1_wdata, m1_wstrb,
    output m1_ready, m1_rdata, m1_err,
    output s_valid, s_addr, s_wdata, s_wstrb,
    input  s_ready, s_rdata
  );

  modport master (
    output m0_valid, m0_addr, m0_wdata, m0_wstrb,
    input  m0_ready, m0_rdata, m0_err,
    output m1_valid, m1_addr, m1_wdata, m1_wstrb,
    input  m1_ready, m1_rdata, m1_err,
    input  s_valid, s_addr, s_wdata, s_wstrb,
    output s_ready, s_rdata
  );

endinterface

// File: rtl/bus_timeout.sv
// BUSY-cycle watchdog: counts enabled cycles since the last clear and flags the final allowed cycle.
module bus_timeout
  import soc_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TIMEOUT_CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= r_count + TIMEOUT_CNT_W'(1);
    end
  end

  assign expired = (r_count == TIMEOUT_CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter of CPU (m0) and DMA (m1) onto one slave bus.
// Optional slave timeout enabled by defining BUS_ARBITER_TIMEOUT_EN.
module bus_arbiter
  import soc_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic           clk,
  input logic           reset,
  bus_arbiter_if.slave  bus
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("bus_arbiter: TIMEOUT_CYCLES must be within 1..65535");
  end

  arb_state_t r_state;
  logic       r_grant;
  logic       r_prio;

  logic       w_busy;
  logic       w_gnt_valid;
  logic       w_done;
  logic       w_tmo;
  logic       w_fin;
  bus_req_t   w_req;

  assign w_busy      = (r_state == BUSY);
  assign w_gnt_valid = (r_grant == DMA) ? bus.m1_valid : bus.m0_valid;
  assign w_done      = w_busy && w_gnt_valid && bus.s_ready;
  assign w_fin       = w_done || w_tmo;
  assign w_req       = (r_grant == DMA) ? {bus.m1_addr, bus.m1_wdata, bus.m1_wstrb}
                                        : {bus.m0_addr, bus.m0_wdata, bus.m0_wstrb};

`ifdef BUS_ARBITER_TIMEOUT_EN
  logic w_expired;

  bus_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (!w_busy),
    .enable  (w_busy && !bus.s_ready),
    .expired (w_expired)
  );

  // s_ready has priority: a timeout only fires when the slave did not answer this cycle.
  assign w_tmo = w_busy && w_gnt_valid && !bus.s_ready && w_expired;
`else
  assign w_tmo = 1'b0;
`endif

  // Arbitration state, grant and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_grant <= CPU;
      r_prio  <= CPU;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.m0_valid && bus.m1_valid) begin
            r_grant <= r_prio;
            r_state <= BUSY;
          end else if (bus.m0_valid) begin
            r_grant <= CPU;
            r_state <= BUSY;
          end else if (bus.m1_valid) begin
            r_grant <= DMA;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          // An abort returns to IDLE without moving the pointer.
          if (!w_gnt_valid) begin
            r_state <= IDLE;
          end else if (w_fin) begin
            r_state <= IDLE;
            r_prio  <= ~r_grant;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Slave request mux and same-cycle completion back to the granted master.
  always_comb begin
    bus.s_valid  = 1'b0;
    bus.s_addr   = '0;
    bus.s_wdata  = '0;
    bus.s_wstrb  = '0;
    bus.m0_ready = 1'b0;
    bus.m0_err   = 1'b0;
    bus.m0_rdata = '0;
    bus.m1_ready = 1'b0;
    bus.m1_err   = 1'b0;
    bus.m1_rdata = '0;

    if (w_busy) begin
      bus.s_valid = w_gnt_valid;
      bus.s_addr  = w_req.addr;
      bus.s_wdata = w_req.wdata;
      bus.s_wstrb = w_req.wstrb;
    end

    if (w_fin) begin
      if (r_grant == DMA) begin
        bus.m1_ready = 1'b1;
        bus.m1_err   = w_tmo;
        bus.m1_rdata = w_done ? bus.s_rdata : '0;
      end else begin
        bus.m0_ready = 1'b1;
        bus.m0_err   = w_tmo;
        bus.m0_rdata = w_done ? bus.s_rdata : '0;
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus a randomized run against a transaction model.
module tb_bus_arbiter;
  import soc_bus_pkg::*;

  localparam int unsigned TMO = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  bus_arbiter_if bif ();

  bus_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  function automatic logic [136:0] all_outs();
    return {bif.s_valid, bif.s_addr, bif.s_wdata, bif.s_wstrb,
            bif.m0_ready, bif.m0_err, bif.m0_rdata,
            bif.m1_ready, bif.m1_err, bif.m1_rdata};
  endfunction

  task automatic idle_inputs();
    bif.m0_valid = 1'b0; bif.m0_addr = '0; bif.m0_wdata = '0; bif.m0_wstrb = '0;
    bif.m1_valid = 1'b0; bif.m1_addr = '0; bif.m1_wdata = '0; bif.m1_wstrb = '0;
    bif.s_ready  = 1'b0; bif.s_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    bif.m0_valid = 1'b1; bif.m0_addr = 32'h1234_5678; bif.s_ready = 1'b1; bif.s_rdata = 32'hFFFF_FFFF;
    #1;
    n_cmp++;
    if (all_outs() !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got %h want 0", all_outs());
    end
    idle_inputs();
  endtask

  task automatic test_single_read();
    logic exp_sv;
    do_reset();
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      bif.m0_valid = (c <= 4); bif.m0_addr = 32'h2000_0010; bif.m0_wstrb = 4'h0;
      bif.s_ready  = (c == 4);
      bif.s_rdata  = (c == 4) ? 32'hDEAD_BEEF : 32'h5555_5555;
      #1;
      exp_sv = (c >= 1 && c <= 4);
      n_cmp++;
      if ({bif.s_valid, bif.s_addr} !== {exp_sv, exp_sv ? 32'h2000_0010 : 32'h0}) begin
        n_bad++; $display("FAIL single_slave c=%0d: got %b/%h want %b", c, bif.s_valid, bif.s_addr, exp_sv);
      end
      n_cmp++;
      if (bif.m0_ready !== (c == 4)) begin
        n_bad++; $display("FAIL single_m0_ready c=%0d: got %b want %b", c, bif.m0_ready, c == 4);
      end
      if (c == 4) begin
        n_cmp++;
        if ({bif.m0_err, bif.m0_rdata} !== {1'b0, 32'hDEAD_BEEF}) begin
          n_bad++; $display("FAIL single_rdata: got err=%b %h want err=0 deadbeef", bif.m0_err, bif.m0_rdata);
        end
      end
      n_cmp++;
      if ({bif.m1_ready, bif.m1_err, bif.m1_rdata} !== '0) begin
        n_bad++; $display("FAIL single_m1_quiet c=%0d: got %b %b %h want 0", c, bif.m1_ready, bif.m1_err, bif.m1_rdata);
      end
    end
    idle_inputs();
  endtask

  task automatic test_fairness();
    int done0 = 0;
    int done1 = 0;
    int own;
    logic [31:0] addr_own;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      bif.m0_valid = (done0 < 4); bif.m0_addr = 32'h0000_0100 + (32'(done0) << 2);
      bif.m1_valid = (done1 < 4); bif.m1_addr = 32'h0000_0200 + (32'(done1) << 2);
      bif.s_ready  = 1'b1;
      bif.s_rdata  = 32'hC000_0000 + 32'(c);
      #1;
      if (c % 2 == 1) begin
        own = (c >> 1) & 1;
        addr_own = (own == 0) ? bif.m0_addr : bif.m1_addr;
        n_cmp++;
        if ({bif.s_valid, bif.s_addr, bif.m0_ready, bif.m1_ready} !== {1'b1, addr_own, own == 0, own == 1}) begin
          n_bad++; $display("FAIL fair_grant c=%0d: got sv=%b addr=%h r0=%b r1=%b want master %0d addr %h",
                            c, bif.s_valid, bif.s_addr, bif.m0_ready, bif.m1_ready, own, addr_own);
        end
        if (bif.m0_ready === 1'b1) done0++;
        if (bif.m1_ready === 1'b1) done1++;
      end else begin
        n_cmp++;
        if ({bif.s_valid, bif.m0_ready, bif.m1_ready} !== 3'b000) begin
          n_bad++; $display("FAIL fair_idle_gap c=%0d: got sv=%b r0=%b r1=%b want 000", c, bif.s_valid, bif.m0_ready, bif.m1_ready);
        end
      end
    end
    n_cmp++;
    if (done0 != 4 || done1 != 4) begin
      n_bad++; $display("FAIL fair_count: got %0d/%0d want 4/4", done0, done1);
    end
    idle_inputs();
  endtask

  task automatic test_write();
    logic exp_sv;
    do_reset();
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      bif.m0_addr  = 32'hFFFF_0000; bif.m0_wdata = 32'h1111_1111; bif.m0_wstrb = 4'hF;
      bif.m1_valid = (c <= 3); bif.m1_addr = 32'h1000_0004; bif.m1_wdata = 32'hA5A5_A5A5; bif.m1_wstrb = 4'h3;
      bif.s_ready  = (c == 3); bif.s_rdata = 32'h0BAD_F00D;
      #1;
      exp_sv = (c >= 1 && c <= 3);
      n_cmp++;
      if ({bif.s_valid, bif.s_addr, bif.s_wdata, bif.s_wstrb} !==
          (exp_sv ? {1'b1, 32'h1000_0004, 32'hA5A5_A5A5, 4'h3} : 69'h0)) begin
        n_bad++; $display("FAIL write_bus c=%0d: got %b %h %h %h want valid=%b", c, bif.s_valid, bif.s_addr, bif.s_wdata, bif.s_wstrb, exp_sv);
      end
      n_cmp++;
      if ({bif.m1_ready, bif.m1_err} !== {c == 3, 1'b0}) begin
        n_bad++; $display("FAIL write_m1_ready c=%0d: got %b err=%b want %b err=0", c, bif.m1_ready, bif.m1_err, c == 3);
      end
      if (c == 3) begin
        n_cmp++;
        if (bif.m1_rdata !== 32'h0BAD_F00D) begin
          n_bad++; $display("FAIL write_m1_rdata: got %h want 0badf00d", bif.m1_rdata);
        end
      end
      n_cmp++;
      if ({bif.m0_ready, bif.m0_err, bif.m0_rdata} !== '0) begin
        n_bad++; $display("FAIL write_m0_quiet c=%0d: got %b %b %h want 0", c, bif.m0_ready, bif.m0_err, bif.m0_rdata);
      end
    end
    idle_inputs();
  endtask

  task automatic test_abort();
    bit m0v [7] = '{1, 1, 0, 0, 0, 1, 1};
    bit m1v [7] = '{0, 0, 1, 1, 0, 1, 1};
    bit sr  [7] = '{0, 1, 0, 0, 1, 0, 1};
    bit e_sv[7] = '{0, 1, 0, 1, 0, 0, 1};
    bit e_r0[7] = '{0, 1, 0, 0, 0, 0, 0};
    bit e_r1[7] = '{0, 0, 0, 0, 0, 0, 1};
    do_reset();
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      bif.m0_valid = m0v[c]; bif.m0_addr = 32'h0000_A000;
      bif.m1_valid = m1v[c]; bif.m1_addr = 32'h0000_B000;
      bif.s_ready  = sr[c];  bif.s_rdata = 32'h7777_0000 + 32'(c);
      #1;
      n_cmp++;
      if ({bif.s_valid, bif.m0_ready, bif.m1_ready} !== {e_sv[c], e_r0[c], e_r1[c]}) begin
        n_bad++; $display("FAIL abort_seq c=%0d: got sv=%b r0=%b r1=%b want %b%b%b",
                          c, bif.s_valid, bif.m0_ready, bif.m1_ready, e_sv[c], e_r0[c], e_r1[c]);
      end
      if (c == 3 || c == 6) begin
        n_cmp++;
        if (bif.s_addr !== 32'h0000_B000) begin
          n_bad++; $display("FAIL abort_owner c=%0d: got %h want 0000b000", c, bif.s_addr);
        end
      end
    end
    idle_inputs();
  endtask

`ifdef BUS_ARBITER_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    for (int c = 0; c <= 9; c++) begin
      @(negedge clk);
      bif.m0_valid = 1'b1; bif.m0_addr = 32'h3000_0000;
      bif.s_ready  = 1'b0; bif.s_rdata = 32'hFFFF_FFFF;
      #1;
      n_cmp++;
      if ({bif.s_valid, bif.m0_ready} !== {c >= 1 && c <= 8, c == 8}) begin
        n_bad++; $display("FAIL tmo_seq c=%0d: got sv=%b r0=%b want %b%b", c, bif.s_valid, bif.m0_ready, c >= 1 && c <= 8, c == 8);
      end
      if (c == 8) begin
        n_cmp++;
        if ({bif.m0_err, bif.m0_rdata} !== {1'b1, 32'h0}) begin
          n_bad++; $display("FAIL tmo_err: got err=%b rdata=%h want err=1 rdata=0", bif.m0_err, bif.m0_rdata);
        end
      end
    end
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      bif.m0_valid = 1'b1; bif.s_ready = (c == 8); bif.s_rdata = 32'h0000_1234;
      #1;
      if (c == 8) begin
        n_cmp++;
        if ({bif.m0_ready, bif.m0_err, bif.m0_rdata} !== {1'b1, 1'b0, 32'h0000_1234}) begin
          n_bad++; $display("FAIL tmo_ready_wins: got %b %b %h want 1 0 00001234", bif.m0_ready, bif.m0_err, bif.m0_rdata);
        end
      end
    end
    idle_inputs();
  endtask
`else
  task automatic test_timeout();
    do_reset();
    for (int c = 0; c <= 1001; c++) begin
      @(negedge clk);
      bif.m0_valid = 1'b1; bif.m0_addr = 32'h3000_0000;
      bif.s_ready  = (c == 1001); bif.s_rdata = 32'h0000_00AB;
      #1;
      if (c >= 1 && c <= 1000) begin
        n_cmp++;
        if ({bif.s_valid, bif.m0_ready, bif.m0_err} !== 3'b100) begin
          n_bad++; $display("FAIL hold_no_timeout c=%0d: got sv=%b r0=%b err=%b want 100", c, bif.s_valid, bif.m0_ready, bif.m0_err);
        end
      end
      if (c == 1001) begin
        n_cmp++;
        if ({bif.m0_ready, bif.m0_err, bif.m0_rdata} !== {1'b1, 1'b0, 32'h0000_00AB}) begin
          n_bad++; $display("FAIL hold_late_ready: got %b %b %h want 1 0 000000ab", bif.m0_ready, bif.m0_err, bif.m0_rdata);
        end
      end
    end
    idle_inputs();
  endtask
`endif

  task automatic test_reset_mid_busy();
    bit m0v[7] = '{1, 1, 0, 0, 0, 1, 1};
    bit m1v[7] = '{0, 0, 1, 1, 1, 1, 1};
    bit sr [7] = '{0, 1, 0, 0, 0, 0, 1};
    do_reset();
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      bif.m0_valid = m0v[c]; bif.m0_addr = 32'h0000_C000;
      bif.m1_valid = m1v[c]; bif.m1_addr = 32'h0000_D000;
      bif.s_ready  = sr[c];  bif.s_rdata = 32'h4444_0000 + 32'(c);
      reset = (c == 4);
      #1;
      if (c == 1) begin
        n_cmp++;
        if (bif.m0_ready !== 1'b1) begin
          n_bad++; $display("FAIL rst_pre_txn: got %b want 1", bif.m0_ready);
        end
      end
      if (c == 4) begin
        n_cmp++;
        if ({bif.s_valid, bif.s_addr} !== {1'b1, 32'h0000_D000}) begin
          n_bad++; $display("FAIL rst_busy_m1: got %b %h want 1 0000d000", bif.s_valid, bif.s_addr);
        end
      end
      if (c == 5) begin
        n_cmp++;
        if (all_outs() !== '0) begin
          n_bad++; $display("FAIL rst_mid_busy_outputs: got %h want 0", all_outs());
        end
      end
      if (c == 6) begin
        n_cmp++;
        if ({bif.s_addr, bif.m0_ready, bif.m1_ready} !== {32'h0000_C000, 1'b1, 1'b0}) begin
          n_bad++; $display("FAIL rst_prio_cleared: got addr=%h r0=%b r1=%b want 0000c000 1 0", bif.s_addr, bif.m0_ready, bif.m1_ready);
        end
      end
    end
    reset = 1'b0;
    idle_inputs();
  endtask

  task automatic test_random(input int ncyc);
    bit          pend [2] = '{1'b0, 1'b0};
    logic [31:0] a    [2] = '{32'h0, 32'h0};
    logic [31:0] d    [2] = '{32'h0, 32'h0};
    logic [3:0]  s    [2] = '{4'h0, 4'h0};
    bit          busy = 1'b0;
    int          own  = 0;
    int          prio = 0;
    int          bcnt = 0;
    bit          sr;
    bit          exp_r;
    logic [31:0] rd;
    logic [68:0] exp_bus;
    logic [33:0] got;
    do_reset();
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i] = 1'b1; a[i] = $urandom(); d[i] = $urandom(); s[i] = 4'($urandom_range(0, 15));
        end
      end
      bif.m0_valid = pend[0]; bif.m0_addr = a[0]; bif.m0_wdata = d[0]; bif.m0_wstrb = s[0];
      bif.m1_valid = pend[1]; bif.m1_addr = a[1]; bif.m1_wdata = d[1]; bif.m1_wstrb = s[1];
      sr = (busy && bcnt >= 3) ? 1'b1 : ($urandom_range(0, 9) < 4);
      rd = $urandom();
      bif.s_ready = sr; bif.s_rdata = rd;
      #1;
      exp_bus = busy ? {1'b1, a[own], d[own], s[own]} : 69'h0;
      n_cmp++;
      if ({bif.s_valid, bif.s_addr, bif.s_wdata, bif.s_wstrb} !== exp_bus) begin
        n_bad++; $display("FAIL rand_bus cyc=%0d: got %b %h %h %h want %h", cyc, bif.s_valid, bif.s_addr, bif.s_wdata, bif.s_wstrb, exp_bus);
      end
      for (int i = 0; i < 2; i++) begin
        got   = (i == 0) ? {bif.m0_ready, bif.m0_err, bif.m0_rdata} : {bif.m1_ready, bif.m1_err, bif.m1_rdata};
        exp_r = busy && sr && (own == i);
        n_cmp++;
        if (got[33] !== exp_r) begin
          n_bad++; $display("FAIL rand_ready m%0d cyc=%0d: got %b want %b", i, cyc, got[33], exp_r);
        end
        if (exp_r) begin
          n_cmp++;
          if (got[32:0] !== {1'b0, rd}) begin
            n_bad++; $display("FAIL rand_rdata m%0d cyc=%0d: got %h want 0_%h", i, cyc, got[32:0], rd);
          end
        end else if (busy && own != i) begin
          n_cmp++;
          if (got[32:0] !== 33'h0) begin
            n_bad++; $display("FAIL rand_nongrant m%0d cyc=%0d: got %h want 0", i, cyc, got[32:0]);
          end
        end
      end
      // Advance the transaction model to the next cycle.
      if (busy) begin
        if (sr) begin
          busy = 1'b0; prio = 1 - own; pend[own] = 1'b0;
        end else begin
          bcnt++;
        end
      end else if (pend[0] || pend[1]) begin
        own  = (pend[0] && pend[1]) ? prio : (pend[0] ? 0 : 1);
        busy = 1'b1;
        bcnt = 0;
      end
    end
    idle_inputs();
    @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_read();
    test_fairness();
    test_write();
    test_abort();
    test_timeout();
    test_reset_mid_busy();
    test_random(400);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: number of BUSY cycles without s_ready before a bus error is returned (range 1..65535).
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  reset; synchronous and active-high.
REQ-004 m0_valid, m1_valid  in  1  request from master 0 (CPU) and master 1 (DMA); held high until the matching ready.
REQ-005 m0_addr, m1_addr  in  32  byte address.
REQ-006 m0_wdata, m1_wdata  in  32  write data.
REQ-007 m0_wstrb, m1_wstrb  in  4  byte write strobes; all zero means read.
REQ-008 m0_ready, m1_ready  out  1  transaction complete for that master, one-cycle pulse.
REQ-009 m0_rdata, m1_rdata  out  32  read data, valid while the matching ready is high.
REQ-010 m0_err, m1_err  out  1  bus error, valid while the matching ready is high.
REQ-011 s_valid  out  1  request to the shared slave bus (the SoC memory decoder).
REQ-012 s_addr, s_wdata, s_wstrb  out  32/32/4  forwarded from the granted master.
REQ-013 s_ready  in  1  slave completion.
REQ-014 s_rdata  in  32  slave read data.

Function
REQ-015 FSM states: IDLE, BUSY; register grant (0/1) and round-robin pointer prio (0/1).
REQ-016 IDLE, exactly one valid: grant = that master, go BUSY next edge.
REQ-017 IDLE, both valid: grant = prio, go BUSY.
REQ-018 IDLE, none valid: stay IDLE; grant and prio unchanged.
REQ-019 s_valid = (state==BUSY) && granted master's valid; it never depends combinationally on an unregistered arbitration decision.
REQ-020 s_addr/s_wdata/s_wstrb mux from the registered grant; all zero in IDLE.
REQ-021 BUSY with s_ready high: the granted mx_ready = 1 and mx_rdata = s_rdata in the same cycle (combinational); mx_err = 0; next state IDLE; prio = ~grant.
REQ-022 The non-granted master's ready, err and rdata are 0 at all times.
REQ-023 BUSY with the granted valid low (abort): no ready is issued; next state IDLE; prio unchanged.
REQ-024 Latency: a request first seen in IDLE at cycle N gives s_valid at N+1; minimum 2 cycles per transaction; after every completion there is 1 IDLE cycle.
REQ-025 Fairness: with both masters continuously requesting, grants strictly alternate.

Reset
REQ-026 Reset high at an edge: state = IDLE, grant = 0, prio = 0, timeout counter = 0.
REQ-027 All outputs are 0 in the cycle after reset, including when reset lands mid-BUSY; the in-flight transaction is dropped without a ready.

Configuration
REQ-028 Macro BUS_ARBITER_TIMEOUT_EN defined: a 16-bit counter clears on entry to BUSY and increments each BUSY cycle without s_ready.
REQ-029 With the macro defined, when the counter equals TIMEOUT_CYCLES-1 with s_ready low, the arbiter asserts the granted mx_ready = 1, mx_err = 1, mx_rdata = 0, drives s_valid = 0 from the next cycle, goes IDLE and sets prio = ~grant.
REQ-030 With the macro defined, if s_ready and timeout fall in the same cycle, s_ready wins (normal completion, err = 0).
REQ-031 Macro undefined: no counter exists, m0_err and m1_err are tied 0, and BUSY waits indefinitely for s_ready.

Structure
REQ-032 Shared package soc_bus_pkg holds: the state encoding (IDLE = 0, BUSY = 1), the master ID constants (CPU = 0, DMA = 1), BUS_ADDR_W = 32, BUS_DATA_W = 32 and BUS_STRB_W = 4.
REQ-033 The timeout counter is a sub-module, bus_timeout (inputs: clear, enable; output: expired), instantiated only under BUS_ARBITER_TIMEOUT_EN; the rest is flat.

Verification
REQ-034 m0 read 0x2000_0010 alone, slave ready after 3 cycles with rdata 0xDEADBEEF: m0_ready pulses with m0_rdata 0xDEADBEEF at cycle 4 after the request; m1 outputs stay 0.
REQ-035 m0 and m1 valid together from reset, slave ready in 1 cycle, 4 requests each: grant order m0, m1, m0, m1, ... with 1 IDLE cycle between transactions.
REQ-036 m1 writes 0xA5A5A5A5 with wstrb 0x3 to 0x1000_0004: s_addr, s_wdata and s_wstrb match exactly while s_valid is high; m1_err = 0.
REQ-037 With BUS_ARBITER_TIMEOUT_EN and TIMEOUT_CYCLES = 8, s_ready held low: m0_ready = 1, m0_err = 1, m0_rdata = 0 on the 8th BUSY cycle, and s_valid = 0 on the next cycle; without the macro, s_valid stays high for 1000 cycles with no ready.
REQ-038 Reset asserted on the 2nd BUSY cycle of an m1 transaction: s_valid = 0 next cycle, no m1_ready, prio = 0, so a following simultaneous request is granted to m0.
